// File: rtl/mcycle.sv
// Iterative multiply/divide unit: 32 iterations of shift-add (mul) or restoring
// shift-subtract (div) on magnitudes, with sign fix-up and special cases applied at completion.
module mcycle (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        Start,
  input  logic [1:0]  MCycleOp,
  input  logic [31:0] Operand1,
  input  logic [31:0] Operand2,
  output logic [31:0] Result1,
  output logic [31:0] Result2,
  output logic        Busy
);
  typedef enum logic [1:0] {IDLE, COMPUTING, DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic        is_div_q, neg_q, rneg_q, div0_q, ovf_q;
  logic [31:0] op1_q, b_q, acc_q, lo_q;
  logic [31:0] res1_q, res2_q;

  // operand preparation at the start edge
  logic        signed_op, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  always_comb begin
    signed_op = ~MCycleOp[0];
    a_neg     = signed_op & Operand1[31];
    b_neg     = signed_op & Operand2[31];
    a_mag     = a_neg ? -Operand1 : Operand1;
    b_mag     = b_neg ? -Operand2 : Operand2;
  end

  // one iteration; acc holds the high product word / partial remainder,
  // lo holds the multiplier being consumed / the quotient being built
  logic [32:0] sum, sh, diff;
  logic [31:0] acc_d, lo_d;
  always_comb begin
    sum  = {1'b0, acc_q} + {1'b0, (lo_q[0] ? b_q : 32'd0)};
    sh   = {acc_q, lo_q[31]};
    diff = sh - {1'b0, b_q};
    if (!is_div_q) begin
      acc_d = sum[32:1];
      lo_d  = {sum[0], lo_q[31:1]};
    end else if (!diff[32]) begin
      acc_d = diff[31:0];
      lo_d  = {lo_q[30:0], 1'b1};
    end else begin
      acc_d = sh[31:0];
      lo_d  = {lo_q[30:0], 1'b0};
    end
  end

  logic [63:0] prod, prod_s;
  logic [31:0] fin1, fin2;
  always_comb begin
    prod   = {acc_d, lo_d};
    prod_s = neg_q ? -prod : prod;
    if (!is_div_q) begin
      fin1 = prod_s[31:0];
      fin2 = prod_s[63:32];
    end else if (div0_q) begin
      fin1 = 32'hFFFF_FFFF;
      fin2 = op1_q;
    end else if (ovf_q) begin
      fin1 = 32'h8000_0000;
      fin2 = 32'h0;
    end else begin
      fin1 = neg_q  ? -lo_d  : lo_d;
      fin2 = rneg_q ? -acc_d : acc_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (Start) begin
          is_div_q <= MCycleOp[1];
          neg_q    <= a_neg ^ b_neg;
          rneg_q   <= a_neg;
          div0_q   <= (Operand2 == 32'h0);
          ovf_q    <= signed_op & (Operand1 == 32'h8000_0000) & (Operand2 == 32'hFFFF_FFFF);
          op1_q    <= Operand1;
          acc_q    <= '0;
          lo_q     <= MCycleOp[1] ? a_mag : b_mag;
          b_q      <= MCycleOp[1] ? b_mag : a_mag;
          cnt_q    <= '0;
          state_q  <= COMPUTING;
        end
        COMPUTING: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            res1_q  <= fin1;
            res2_q  <= fin2;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy    = RESETn & (((state_q == IDLE) & Start) | (state_q == COMPUTING));
  assign Result1 = res1_q;
  assign Result2 = res2_q;
endmodule

// File: tb/tb_mcycle.sv
// Directed bench for mcycle: arithmetic reference model plus per-cycle compare of
// Busy/Result1/Result2, and literal checks for the listed vectors.
module tb_mcycle;
  logic        CLK = 0, RESETn = 0, Start = 0;
  logic [1:0]  MCycleOp = 0;
  logic [31:0] Operand1 = 0, Operand2 = 0;
  logic [31:0] Result1, Result2;
  logic        Busy;

  mcycle dut (.CLK(CLK), .RESETn(RESETn), .Start(Start), .MCycleOp(MCycleOp),
              .Operand1(Operand1), .Operand2(Operand2),
              .Result1(Result1), .Result2(Result2), .Busy(Busy));

  always #5 CLK = ~CLK;

  int nvec = 0, nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic, returns {Result1, Result2}
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p, ua, ub;
    longint      sa, sb;
    int          ia, ib;
    logic [31:0] q, r;
    if (!op[1]) begin
      if (op[0]) begin ua = {32'h0, a}; ub = {32'h0, b}; p = ua * ub; end
      else begin sa = longint'($signed(a)); sb = longint'($signed(b)); p = 64'(sa * sb); end
      return {p[31:0], p[63:32]};
    end
    if (b == 0) return {32'hFFFF_FFFF, a};
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    if (op[0]) begin q = a / b; r = a % b; end
    else begin ia = $signed(a); ib = $signed(b); q = 32'(ia / ib); r = 32'(ia % ib); end
    return {q, r};
  endfunction

  // Timing model: countdown of remaining compute cycles, plus a done flag
  int          m_cnt = 0;
  bit          m_done = 0, chk_en = 0;
  logic [31:0] m_r1 = 0, m_r2 = 0;
  logic [63:0] m_pend = 0;

  always @(posedge CLK) begin
    chk_en <= 1;
    if (!RESETn) begin
      m_cnt <= 0; m_done <= 0; m_r1 <= 0; m_r2 <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done <= 1;
        m_r1 <= m_pend[63:32];
        m_r2 <= m_pend[31:0];
      end
    end else if (Start) begin
      m_pend <= model(MCycleOp, Operand1, Operand2);
      m_cnt  <= 32;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("busy",    {31'h0, Busy},
          {31'h0, RESETn && ((m_cnt == 0 && !m_done && Start) || m_cnt > 0)});
      chk("result1", Result1, m_r1);
      chk("result2", Result2, m_r2);
    end
  end

  // Issue one op at posedge+1; returns at posedge+1 of the IDLE cycle after DONE
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e1, input logic [31:0] e2,
                        input bit hold);
    int  n = 0;
    bit  fin = 0;
    Start = 1; MCycleOp = op; Operand1 = a; Operand2 = b;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (!Busy) begin fin = 1; break; end
      n++;
      @(posedge CLK); #1;
      if (!hold) Start = 0;
      Operand1 = $urandom; Operand2 = $urandom; MCycleOp = 2'($urandom);
    end
    if (!fin) chk({name, "_timeout"}, 32'h0, 32'h1);
    chk({name, "_busycycles"}, 32'(n), 32'd33);
    chk({name, "_r1"}, Result1, e1);
    chk({name, "_r2"}, Result2, e2);
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [63:0] mr;
    bit          fin;
    // reset with Start high: Busy must stay low
    Start = 1; MCycleOp = 2'b01; Operand1 = 32'h1234; Operand2 = 32'h5678;
    repeat (2) @(posedge CLK);
    #1;
    RESETn = 1;

    mr = model(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); chk("model_umul", mr[63:32] ^ mr[31:0], 32'hFFFF_FFFF);
    mr = model(2'b00, 32'hFFFF_FFFD, 32'd7);         chk("model_smul_lo", mr[63:32], 32'hFFFF_FFEB);
    mr = model(2'b10, 32'hFFFF_FFF9, 32'd2);         chk("model_sdiv_rem", mr[31:0], 32'hFFFF_FFFF);
    mr = model(2'b10, 32'hFFFF_FFFB, 32'd0);         chk("model_div0_rem", mr[31:0], 32'hFFFF_FFFB);

    // first op issued in the very first cycle after reset release
    run_op("umul_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 0);
    run_op("smul_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 0);
    run_op("sdiv_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    run_op("udiv_5_0",  2'b11, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'h0000_0005, 0);
    run_op("sdiv_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 0);
    run_op("sdiv_ovf",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 0);
    run_op("udiv_100_7",2'b11, 32'd100,       32'd7,         32'd14,        32'd2,         0);
    run_op("sdiv_7_m2", 2'b10, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         0);
    run_op("sdiv_m8_m3",2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2,         32'hFFFF_FFFE, 0);
    run_op("smul_minsq",2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0,         32'h4000_0000, 0);
    run_op("umul_2p32", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0,         32'h1,         0);

    // Start held through completion: one op, then a fresh op in the following IDLE cycle
    run_op("hold", 2'b11, 32'd6, 32'd4, 32'd1, 32'd2, 1);
    @(negedge CLK);
    chk("hold_restart_busy", {31'h0, Busy}, 32'h1);
    @(posedge CLK); #1;
    Start = 0;
    fin = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (!Busy) begin fin = 1; break; end
    end
    if (!fin) chk("hold_restart_timeout", 32'h0, 32'h1);
    @(posedge CLK); #1;

    // reset pulse on COMPUTING cycle 10 discards the op
    Start = 1; MCycleOp = 2'b01; Operand1 = 32'hDEAD_BEEF; Operand2 = 32'h1234_5678;
    @(posedge CLK); #1;
    Start = 0;
    repeat (9) begin @(posedge CLK); #1; end
    RESETn = 0; Start = 1;
    @(negedge CLK);
    chk("rst_busy_low", {31'h0, Busy}, 32'h0);
    @(posedge CLK); #1;
    RESETn = 1; Start = 0;
    @(negedge CLK);
    chk("post_rst_busy", {31'h0, Busy}, 32'h0);
    chk("post_rst_r1", Result1, 32'h0);
    chk("post_rst_r2", Result2, 32'h0);
    @(posedge CLK); #1;
    run_op("udiv_6_4", 2'b11, 32'd6, 32'd4, 32'd1, 32'd2, 0);

    repeat (2) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
